// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a sync FIFO: pops one byte per frame and serialises it as
// start, LSB-first data, optional parity and stop bit(s) on a registered tx line.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_re,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(WIDTH) + 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StLoad   = 3'd2;
  localparam logic [2:0] StStart  = 3'd3;
  localparam logic [2:0] StData   = 3'd4;
  localparam logic [2:0] StParity = 3'd5;
  localparam logic [2:0] StStop   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             baud_last;
  logic             timed_state;

  assign baud_last   = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign timed_state = (state_q == StStart) || (state_q == StData) ||
                       (state_q == StParity) || (state_q == StStop);

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      StIdle:  if (tx_en && !fifo_empty) state_d = StFetch;
      StFetch: state_d = StLoad;
      StLoad: begin
        shift_d = fifo_dout;
        par_d   = (^fifo_dout) ^ (PARITY_ODD != 0);
        state_d = StStart;
      end
      StStart: if (baud_last) state_d = StData;
      StData: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == BitW'(WIDTH - 1)) state_d = (PARITY_EN != 0) ? StParity : StStop;
          else                           bit_d   = bit_q + 1'b1;
        end
      end
      StParity: if (baud_last) state_d = StStop;
      StStop: begin
        if (baud_last) begin
          if (bit_q == BitW'(STOP_BITS - 1)) state_d = StIdle;
          else                               bit_d   = bit_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Both counters restart on every state change so each bit period begins at zero.
    if (state_d != state_q) begin
      baud_d = '0;
      bit_d  = '0;
    end else if (timed_state) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign fifo_re    = (state_q == StFetch);
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StStop) && baud_last && (bit_q == BitW'(STOP_BITS - 1));
  assign tx         = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a behavioural FIFO feeds the main instance; two parity
// instances are fed from a held data word to cover even/odd parity and two stop bits.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_re, tx, busy, frame_done;

  logic       p_empty;
  logic [7:0] p_dout;
  logic       pe_re, pe_tx, pe_busy, pe_fd;
  logic       po_re, po_tx, po_busy, po_fd;

  int n_checks = 0;
  int n_err    = 0;
  int fd_cnt   = 0;

  logic [7:0] mem [0:63];
  int wr_cnt = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_re(fifo_re), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_pe (
    .clk(clk), .rst(rst), .tx_en(1'b1), .fifo_empty(p_empty), .fifo_dout(p_dout),
    .fifo_re(pe_re), .tx(pe_tx), .busy(pe_busy), .frame_done(pe_fd)
  );

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
    .clk(clk), .rst(rst), .tx_en(1'b1), .fifo_empty(p_empty), .fifo_dout(p_dout),
    .fifo_re(po_re), .tx(po_tx), .busy(po_busy), .frame_done(po_fd)
  );

  // FIFO model: registered read data, valid the cycle after the strobe.
  assign fifo_empty = (wr_cnt == rd_cnt);
  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_dout <= mem[rd_cnt % 64];
      rd_cnt    <= rd_cnt + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic push(input logic [7:0] d);
    mem[wr_cnt % 64] = d;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of the first start-bit cycle; leaves at the following IDLE cycle.
  task automatic check_frame(input logic [7:0] d, input string tag, input bit drop);
    logic [3:0] v, f;
    logic b;
    for (int i = 0; i < 10; i++) begin
      b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
      for (int c = 0; c < 4; c++) begin
        if (drop && i == 4 && c == 0) tx_en = 1'b0;
        v[c] = tx;
        f[c] = frame_done;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d", tag, i), {v, f}, {{4{b}}, (i == 9) ? 4'b1000 : 4'b0000});
    end
  endtask

  // Entered at an IDLE-cycle negedge with data available: IDLE, FETCH, LOAD, then the frame.
  task automatic run_frame(input logic [7:0] d, input string tag, input bit drop);
    chk({tag, " idle"},  {tx, busy, fifo_re}, 3'b100);
    @(negedge clk);
    chk({tag, " fetch"}, {tx, busy, fifo_re}, 3'b111);
    @(negedge clk);
    chk({tag, " load"},  {tx, busy, fifo_re}, 3'b110);
    @(negedge clk);
    check_frame(d, tag, drop);
  endtask

  // Index 0 is the first start-bit cycle; parity occupies 36..39, stop begins at 40.
  task automatic par_run(input logic [7:0] d, input logic p_even, input logic p_odd,
                         input string tag);
    logic [47:0] te, to, fe, fo;
    p_dout  = d;
    p_empty = 1'b0;
    @(negedge clk);
    chk({tag, " fetch"}, {pe_re, po_re}, 2'b11);
    p_empty = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 48; k++) begin
      te[k] = pe_tx;
      to[k] = po_tx;
      fe[k] = pe_fd;
      fo[k] = po_fd;
      @(negedge clk);
    end
    chk({tag, " even data"}, te[35:0], {{4{d[7]}}, {4{d[6]}}, {4{d[5]}}, {4{d[4]}}, {4{d[3]}},
                                        {4{d[2]}}, {4{d[1]}}, {4{d[0]}}, 4'b0000});
    chk({tag, " even par+stop"}, te[47:36], {8'hFF, {4{p_even}}});
    chk({tag, " odd par+stop"},  to[43:36], {4'hF, {4{p_odd}}});
    chk({tag, " even done"}, fe, 48'h8000_0000_0000);
    chk({tag, " odd done"},  fo, 48'h0800_0000_0000);
    chk({tag, " idle after"}, {pe_busy, po_busy, pe_tx, po_tx}, 4'b0011);
  endtask

  initial begin
    logic bad;
    rst     = 1'b1;
    tx_en   = 1'b0;
    p_empty = 1'b1;
    p_dout  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset main", {tx, busy, fifo_re, frame_done}, 4'b1000);
    chk("reset parity", {pe_tx, pe_busy, pe_re, po_tx, po_busy, po_re}, 6'b100100);
    rst = 1'b0;
    @(negedge clk);

    // Empty FIFO with transmission enabled: line stays idle, no pops.
    tx_en = 1'b1;
    bad   = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_re !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("empty idle", bad, 1'b0);

    push(8'hA5);
    run_frame(8'hA5, "single", 1'b0);
    chk("single busy", busy, 1'b0);
    chk("single pops", rd_cnt, 1);
    chk("single done", fd_cnt, 1);
    chk("single empty", fifo_empty, 1'b1);

    push(8'h01);
    push(8'h80);
    push(8'hFF);
    run_frame(8'h01, "burst0", 1'b0);
    run_frame(8'h80, "burst1", 1'b0);
    run_frame(8'hFF, "burst2", 1'b0);
    chk("burst busy", busy, 1'b0);
    chk("burst pops", rd_cnt, 4);
    chk("burst empty", fifo_empty, 1'b1);

    tx_en = 1'b0;
    push(8'h3C);
    push(8'hC3);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_re !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    chk("disabled idle", bad, 1'b0);
    chk("disabled level", wr_cnt - rd_cnt, 2);

    // tx_en drops during data bit 3: frame finishes, second byte stays queued.
    tx_en = 1'b1;
    run_frame(8'h3C, "drop", 1'b1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_re !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("drop no fetch", bad, 1'b0);
    chk("drop level", wr_cnt - rd_cnt, 1);
    chk("drop done", fd_cnt, 5);

    // Reset in the middle of data bit 2 of 0xC3; 0x5A must follow normally.
    push(8'h5A);
    tx_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    repeat (13) @(negedge clk);
    chk("pre-reset tx", {tx, busy}, 2'b01);
    #1 rst = 1'b1;
    #1 chk("async reset", {tx, busy, frame_done, fifo_re}, 4'b1000);
    @(negedge clk);
    rst = 1'b0;
    run_frame(8'h5A, "after rst", 1'b0);
    chk("rst pops", rd_cnt, 7);
    chk("rst empty", fifo_empty, 1'b1);
    chk("rst done", fd_cnt, 6);

    par_run(8'h07, 1'b1, 1'b0, "par07");
    par_run(8'h00, 1'b0, 1'b1, "par00");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected end of sequence");
    $fatal(1, "timeout");
  end

endmodule
